// File: rtl/mario_input_pkg.sv
// Shared definitions for the PS/2 keypad front end of the Mario input path.
// Contents:
//   - scan-code set 2 constants for the prefix bytes and the mapped keys
//   - decode FSM state encoding and key action encoding
//   - held-key bundle type
//   - timeout_cyc(): PS/2 inter-edge timeout expressed in system clocks
//   - map_key():     scan code (+ extended flag) -> game action
package mario_input_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;  // extended
  localparam logic [7:0] SC_RIGHT = 8'h74;  // extended
  localparam logic [7:0] SC_UP    = 8'h75;  // extended

  // Index of the stop bit: a frame is start, 8 data, parity, stop.
  localparam logic [3:0] LAST_BIT = 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_LEFT  = 2'd1,
    ACT_RIGHT = 2'd2,
    ACT_JUMP  = 2'd3
  } key_act_t;

  // jump[0] is fed by the normal keys (W/Space), jump[1] by extended Up,
  // so releasing one jump key does not cancel the other.
  typedef struct packed {
    logic       left;
    logic       right;
    logic [1:0] jump;
  } held_t;

  function automatic int timeout_cyc(input int clk_hz, input int timeout_us);
    return clk_hz / 1000000 * timeout_us;
  endfunction

  function automatic key_act_t map_key(input logic [7:0] code, input logic ext);
    key_act_t act;
    act = ACT_NONE;
    if (ext) begin
      case (code)
        SC_LEFT:  act = ACT_LEFT;
        SC_RIGHT: act = ACT_RIGHT;
        SC_UP:    act = ACT_JUMP;
        default:  act = ACT_NONE;
      endcase
    end else begin
      case (code)
        SC_A:           act = ACT_LEFT;
        SC_D:           act = ACT_RIGHT;
        SC_W, SC_SPACE: act = ACT_JUMP;
        default:        act = ACT_NONE;
      endcase
    end
    return act;
  endfunction

endpackage

// File: rtl/ps2_keypad_if.sv
// Keypad result bundle between the PS/2 front end and the Mario controller.
//   left/right/jump : level, action key held (left/right mutually exclusive)
//   key_valid       : one-cycle pulse per accepted byte
//   key_code        : last accepted byte, held between pulses
//   frame_err       : one-cycle pulse per rejected or timed-out frame
// master = the keypad (drives everything), slave = the consumer.
interface ps2_keypad_if;
  logic       left;
  logic       right;
  logic       jump;
  logic       key_valid;
  logic [7:0] key_code;
  logic       frame_err;

  modport master (output left, right, jump, key_valid, key_code, frame_err);
  modport slave  (input  left, right, jump, key_valid, key_code, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver.
// Ports:
//   clk, rst        : system clock, asynchronous active-low reset
//   ps2_clk/ps2_data: raw pins, asynchronous to clk
//   rx_byte         : last accepted data byte (held)
//   byte_valid      : one-cycle pulse, cycle after the stop-bit sample
//   byte_err        : one-cycle pulse for a bad frame or an inter-edge timeout
// Both pins go through a two-flop synchronizer; a falling edge of the
// synchronized clock marks the sample cycle in which the data bit is taken.
module ps2_frame_rx
  import mario_input_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int TMO = timeout_cyc(CLK_HZ, TIMEOUT_US);
  localparam int TW  = $clog2(TMO + 1);

  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift_q;
  logic          start_q;
  logic          par_q;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          frame_ok;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_prev <= 1'b0;
      dat_s1   <= 1'b0;
      dat_s2   <= 1'b0;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall     = clk_prev & ~clk_s2;
  // The timeout only runs inside a frame; idle lines never raise an error.
  assign tmo_hit  = (bit_cnt != 4'd0) && (tmo_cnt == TW'(TMO - 1));
  // Judged in the stop-bit sample cycle: dat_s2 is the stop bit itself.
  assign frame_ok = ~start_q & (^shift_q ^ par_q) & dat_s2;

  // NOTE: the shift register and captured bits are reset along with the
  // control state so a reset mid-frame leaves no stale partial byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= 4'd0;
      shift_q    <= 8'h00;
      start_q    <= 1'b0;
      par_q      <= 1'b0;
      tmo_cnt    <= '0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (tmo_hit) begin
        // An edge coinciding with the timeout is dropped on purpose; the
        // next frame restarts cleanly from the start bit.
        bit_cnt  <= 4'd0;
        tmo_cnt  <= '0;
        byte_err <= 1'b1;
      end else if (fall) begin
        tmo_cnt <= '0;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            byte_valid <= 1'b1;
            rx_byte    <= shift_q;
          end else begin
            byte_err   <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          case (bit_cnt)
            4'd0:    start_q <= dat_s2;
            4'd9:    par_q   <= dat_s2;
            default: shift_q <= {dat_s2, shift_q[7:1]};  // LSB first
          endcase
        end
      end else if (bit_cnt != 4'd0) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard front end for the Mario character controller.
// Ports:
//   clk, rst          : system clock, asynchronous active-low reset
//   ps2_clk, ps2_data : raw PS/2 pins
//   kp (master)       : left/right/jump levels, key_valid/key_code, frame_err
// Accepted bytes walk a set-2 make/break decoder (E0 / F0 prefixes) that
// sets or clears one held bit per action. Output levels are registered from
// the held bits, two cycles after the stop-bit sample.
module ps2_keypad
  import mario_input_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int TIMEOUT_US = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  ps2_keypad_if.master kp
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       byte_err;

  ps2_frame_rx #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  assign kp.key_valid = byte_valid;
  assign kp.key_code  = rx_byte;
  assign kp.frame_err = byte_err;

  dec_state_t state_q, state_d;
  held_t      held_q, held_d;
  logic       apply_key;
  logic       is_ext;
  logic       is_make;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      held_q   <= '0;
      kp.left  <= 1'b0;
      kp.right <= 1'b0;
      kp.jump  <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      // Opposing directions cancel rather than picking a winner.
      kp.left  <= held_d.left & ~held_d.right;
      kp.right <= held_d.right & ~held_d.left;
      kp.jump  <= |held_d.jump;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    held_d    = held_q;
    apply_key = 1'b0;
    is_ext    = 1'b0;
    is_make   = 1'b0;

    if (byte_err) begin
      // A damaged byte may have been the second half of a sequence; drop
      // any pending prefix rather than misinterpreting the next byte.
      state_d = IDLE;
    end else if (byte_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_byte == SC_EXT) begin
            state_d = EXT;
          end else if (rx_byte == SC_BRK) begin
            state_d = BRK;
          end else begin
            apply_key = 1'b1;
            is_make   = 1'b1;
          end
        end
        EXT: begin
          if (rx_byte == SC_BRK) begin
            state_d = EXT_BRK;
          end else begin
            apply_key = 1'b1;
            is_ext    = 1'b1;
            is_make   = 1'b1;
            state_d   = IDLE;
          end
        end
        BRK: begin
          apply_key = 1'b1;
          state_d   = IDLE;
        end
        EXT_BRK: begin
          apply_key = 1'b1;
          is_ext    = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Writing the make/break value directly makes typematic repeats
      // idempotent and lets unmapped codes fall through untouched.
      if (apply_key) begin
        case (map_key(rx_byte, is_ext))
          ACT_LEFT:  held_d.left         = is_make;
          ACT_RIGHT: held_d.right        = is_make;
          ACT_JUMP:  held_d.jump[is_ext] = is_make;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keypad.sv
// Self-checking bench for ps2_keypad: a key_code scoreboard fed by the frame
// sender, a table of byte sequences with expected action levels, and
// hand-written sequences for reset, cycle timing, bad frames and timeout.
module tb_ps2_keypad;

  localparam int CLK_HZ     = 10000000;
  localparam int TIMEOUT_US = 50;
  localparam int TMO        = CLK_HZ / 1000000 * TIMEOUT_US;  // 500 cycles
  localparam int HALF       = 20;  // system clocks per PS/2 half period
  localparam int GAP        = 40;  // idle clocks after each frame

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_keypad_if kp ();

  ps2_keypad #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kp       (kp)
  );

  always #5 clk = ~clk;

  int total    = 0;
  int bad      = 0;
  int kv_seen  = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic [1:0]      n;
    logic [2:0][7:0] b;
    logic            l;
    logic            r;
    logic            j;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vt[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic l, input logic r, input logic j);
    check({name, "_left"},  32'(kp.left),  32'(l));
    check({name, "_right"}, 32'(kp.right), 32'(r));
    check({name, "_jump"},  32'(kp.jump),  32'(j));
  endtask

  // Scoreboard: every key_valid pulse must match the oldest expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && kp.key_valid) begin
        kv_seen++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_key_valid: got code %0h want no pulse", kp.key_code);
        end else begin
          check("key_code", 32'(kp.key_code), 32'(exp_q.pop_front()));
        end
      end
      if (rst && kp.frame_err) err_seen++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic bad_par,
                                             input logic bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    exp_q.push_back(d);
    send_bits(make_frame(d, 1'b0, 1'b0), 11);
    wait_cyc(GAP);
  endtask

  task automatic send_bad(input logic [7:0] d, input logic bp, input logic bs);
    send_bits(make_frame(d, bp, bs), 11);
    wait_cyc(GAP);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(2);
  endtask

  task automatic set_vec(input int i, input logic [1:0] n, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2,
                         input logic l, input logic r, input logic j);
    vt[i].n    = n;
    vt[i].b[0] = b0;
    vt[i].b[1] = b1;
    vt[i].b[2] = b2;
    vt[i].l    = l;
    vt[i].r    = r;
    vt[i].j    = j;
  endtask

  initial begin
    logic [10:0] f;
    int k0;
    int e0;

    set_vec(0,  1, 8'h1C, 8'h00, 8'h00, 1, 0, 0);
    set_vec(1,  1, 8'h23, 8'h00, 8'h00, 0, 0, 0);
    set_vec(2,  2, 8'hF0, 8'h1C, 8'h00, 0, 1, 0);
    set_vec(3,  2, 8'hE0, 8'h75, 8'h00, 0, 1, 1);
    set_vec(4,  1, 8'h29, 8'h00, 8'h00, 0, 1, 1);
    set_vec(5,  3, 8'hE0, 8'hF0, 8'h75, 0, 1, 1);
    set_vec(6,  2, 8'hF0, 8'h29, 8'h00, 0, 1, 0);
    set_vec(7,  2, 8'hF0, 8'h23, 8'h00, 0, 0, 0);
    set_vec(8,  1, 8'hE1, 8'h00, 8'h00, 0, 0, 0);
    set_vec(9,  2, 8'hE0, 8'h6B, 8'h00, 1, 0, 0);
    set_vec(10, 1, 8'h1C, 8'h00, 8'h00, 1, 0, 0);
    set_vec(11, 3, 8'hE0, 8'hF0, 8'h6B, 0, 0, 0);
    set_vec(12, 1, 8'h1D, 8'h00, 8'h00, 0, 0, 1);
    set_vec(13, 1, 8'h1D, 8'h00, 8'h00, 0, 0, 1);
    set_vec(14, 2, 8'hF0, 8'h1D, 8'h00, 0, 0, 0);

    // Reset state, then an async reset in the middle of a frame.
    wait_cyc(5);
    check_out("in_reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    wait_cyc(5);
    send_byte(8'h1D);
    check_out("pre_reset", 1'b0, 1'b0, 1'b1);
    send_bits(make_frame(8'h23, 1'b0, 1'b0), 5);
    rst = 1'b0;
    #1;
    check_out("async_reset", 1'b0, 1'b0, 1'b0);
    check("async_reset_key_code", 32'(kp.key_code), 32'h0);
    check("async_reset_key_valid", 32'(kp.key_valid), 32'h0);
    check("async_reset_frame_err", 32'(kp.frame_err), 32'h0);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(5);

    // Clean 1C with exact latency from the stop-bit falling edge.
    exp_q.push_back(8'h1C);
    f = make_frame(8'h1C, 1'b0, 1'b0);
    send_bits(f, 10);
    ps2_data = f[10];
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("sample_cycle_key_valid", 32'(kp.key_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("s1_key_valid", 32'(kp.key_valid), 32'h1);
    check("s1_left", 32'(kp.left), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("s2_key_valid", 32'(kp.key_valid), 32'h0);
    check("s2_left", 32'(kp.left), 32'h1);
    wait_cyc(HALF - 3);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(GAP);
    check("after_1c_drained", 32'(exp_q.size()), 32'h0);

    // Extended right make, then extended break.
    do_reset();
    k0 = kv_seen;
    send_byte(8'hE0);
    send_byte(8'h74);
    check_out("ext_right_make", 1'b0, 1'b1, 1'b0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    check("ext_prefix_pulses", 32'(kv_seen - k0), 32'd4);
    check_out("ext_break_pending", 1'b0, 1'b1, 1'b0);
    send_byte(8'h74);
    check_out("ext_right_break", 1'b0, 1'b0, 1'b0);
    check("ext_total_pulses", 32'(kv_seen - k0), 32'd5);

    // Table of sequences with the expected levels after each.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      for (int k = 0; k < int'(vt[i].n); k++) send_byte(vt[i].b[k]);
      check_out($sformatf("vec%0d", i), vt[i].l, vt[i].r, vt[i].j);
    end
    check("table_drained", 32'(exp_q.size()), 32'h0);

    // Parity error on Space, then a good Space.
    do_reset();
    e0 = err_seen;
    k0 = kv_seen;
    send_bad(8'h29, 1'b1, 1'b0);
    check("parity_err_pulses", 32'(err_seen - e0), 32'd1);
    check("parity_err_no_kv", 32'(kv_seen - k0), 32'd0);
    check("parity_err_jump", 32'(kp.jump), 32'h0);
    send_byte(8'h29);
    check("parity_recover_jump", 32'(kp.jump), 32'h1);
    check("parity_recover_err", 32'(err_seen - e0), 32'd1);

    // Frame abandoned after 4 bits; timeout then a fresh frame.
    do_reset();
    e0 = err_seen;
    send_bits(make_frame(8'h1D, 1'b0, 1'b0), 4);
    wait_cyc(TMO - 60);
    check("timeout_not_early", 32'(err_seen - e0), 32'd0);
    wait_cyc(70);
    check("timeout_pulse", 32'(err_seen - e0), 32'd1);
    send_byte(8'h1D);
    check("timeout_recover_jump", 32'(kp.jump), 32'h1);
    check("timeout_recover_err", 32'(err_seen - e0), 32'd1);
    check("timeout_drained", 32'(exp_q.size()), 32'h0);

    // Bad stop after E0 must drop the extended prefix.
    do_reset();
    e0 = err_seen;
    send_byte(8'hE0);
    send_bad(8'h74, 1'b0, 1'b1);
    send_byte(8'h6B);
    check("stop_err_pulses", 32'(err_seen - e0), 32'd1);
    check_out("prefix_dropped", 1'b0, 1'b0, 1'b0);
    send_byte(8'hE0);
    send_byte(8'h6B);
    check_out("ext_left_after", 1'b1, 1'b0, 1'b0);
    check("final_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_keypad.md
Name: ps2_keypad

Overview:
- PS/2 keyboard front end that produces the `left`, `right` and `jump` level inputs consumed by the Mario character controller.
- Receives PS/2 device-to-host frames on the raw `ps2_clk`/`ps2_data` pins.
- Decodes scan-code set 2 make/break sequences and holds one pressed-state bit per action.
- Sits between the board PS/2 connector and the Mario block, clocked by the system `clk`.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- TIMEOUT_US, 200, maximum time between consecutive PS/2 falling edges inside one frame before the frame is aborted.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock, asynchronous to `clk`.
- ps2_data  input  1  raw PS/2 data, asynchronous to `clk`.
- left  output  1  level; move-left key held.
- right  output  1  level; move-right key held.
- jump  output  1  level; jump key held.
- key_valid  output  1  one-cycle pulse per accepted byte.
- key_code  output  8  last accepted byte; valid while `key_valid` is high, held otherwise.
- frame_err  output  1  one-cycle pulse per rejected or aborted frame.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`rst`). Every output, every internal register and the FSM return to zero/IDLE immediately, including mid-frame.
- Synchronizer: two flops on each of `ps2_clk` and `ps2_data`, then a falling-edge detect on the synchronized clock. The cycle in which the edge is detected is the "sample cycle"; synchronized data is captured in that cycle.
- Frame format: 11 bits in order — start=0, 8 data bits LSB first, odd parity, stop=1. A bit counter runs 0..10.
- Accepted frame, judged on bit 10: requires start==0, XOR of data and parity ==1, and stop==1.
  - `key_valid`=1 and `key_code`=byte in the cycle after the sample cycle of bit 10.
- Rejected frame (start, parity or stop error):
  - `frame_err` pulses in the same cycle position instead of `key_valid`.
  - Byte is discarded; decode FSM forced to IDLE; held bits unchanged.
- Timeout:
  - TIMEOUT_CYC = CLK_HZ/1000000*TIMEOUT_US cycles.
  - The counter runs while bit counter != 0 and clears on each falling edge.
  - On reaching TIMEOUT_CYC: bit counter := 0, `frame_err` pulses once, decode FSM := IDLE.
  - The timeout is inactive while idle (bit counter 0).
- Decode FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions on accepted bytes:
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make, stay IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> extended make -> IDLE.
  - BRK: any byte -> break -> IDLE.
  - EXT_BRK: any byte -> extended break -> IDLE.
- Key map. Make sets the held bit; break clears it.
  - Normal: 1C (A) -> left; 23 (D) -> right; 1D (W) and 29 (Space) -> jump.
  - Extended: 6B -> left; 74 -> right; 75 -> jump.
  - Unmapped codes, including E1 and pause sequences, change no held bit.
  - Repeated make (typematic) is idempotent.
- Jump source: jump_held is a 2-bit set (normal W/Space, extended up). `jump` = OR of the set.
- Held-bit timing: held bits update in the same cycle `key_valid` is high.
- Output registers:
  - `left` = left_held & ~right_held.
  - `right` = right_held & ~left_held.
  - Both held -> both 0.
  - Outputs appear one cycle after the held-bit update, i.e. 2 cycles after the sample cycle of bit 10.
- Simultaneous events: a falling edge arriving in the cycle the timeout fires is ignored. Next frame restarts from bit 0.

Decomposition:
- Package `mario_input_pkg`:
  - scan-code localparams (SC_EXT=8'hE0, SC_BRK=8'hF0, SC_A, SC_D, SC_W, SC_SPACE, SC_LEFT, SC_RIGHT, SC_UP);
  - decode FSM state encoding;
  - TIMEOUT_CYC function.
- Sub-module `ps2_frame_rx` covers synchronizer, edge detect, shift register, parity check and timeout. Its outputs are byte[7:0], byte_valid and byte_err.
- `ps2_keypad` instantiates it and holds the decode FSM and output logic.

Test Plan:
1. Reset low mid-frame (after 5 bits), then high; then a clean frame 1C -> all outputs 0 during reset; `key_valid` with `key_code`=1C; `left`=1 two cycles after the sample cycle of bit 10.
2. Send E0 74, then E0 F0 74 -> `right`=1 after the first sequence, 0 after the second; four `key_valid` pulses before the F0 74 break completes.
3. Send 1C, then 23 (A+D both held) -> `left`=`right`=0; then F0 1C -> `right`=1, `left`=0.
4. Frame 29 with parity bit flipped -> `frame_err` single pulse, no `key_valid`, `jump` stays 0; next good frame 29 -> `jump`=1.
5. Stop after 4 bits; wait TIMEOUT_CYC+10 cycles; then send full frame 1D -> one `frame_err` pulse at timeout; `key_code`=1D accepted; `jump`=1.
6. Send E0 followed by a bad-stop frame, then 6B -> FSM returned to IDLE, so 6B decodes as normal (unmapped) and `left` stays 0.
